trio_sample_packer: RTL and testbench

Downstream capture stage for the three single-bit outputs of the top-level M8 instantiation hierarchy (out8_1, out8_2, out8_3). It accepts one 3-bit sample per handshake and packs SAMPLES consecutive samples into one wide word. Words leave through a valid/ready output port with back-pressure, and a flush emits a partial word. It also keeps a saturating per-channel toggle count, so the bench can observe activity on the datagraph outputs without storing a full trace.

---
 rtl/trio_sample_packer.sv | 184 ++++++++++++++++++
 tb/tb_trio_sample_packer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trio_sample_packer.sv
// Packs 3-bit samples (out8_1..out8_3) into SAMPLES-wide words behind a valid/ready port,
// with flush of partial words and saturating per-channel toggle counters.
module trio_sample_packer #(
    parameter int SAMPLES = 4,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = $clog2(SAMPLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [2:0]           in_bits,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*SAMPLES-1:0] out_data,
    output logic [IDX_W-1:0]     out_count,
    input  logic                 clear_cnt,
    output logic [3*CNT_W-1:0]   toggle_cnt,
    output logic [2:0]           toggle_sat
);

    // state   | meaning
    // ST_FILL | accepting samples into the fill register
    // ST_PEND | flush requested; waiting for a free out slot to emit the partial word
    typedef enum logic {ST_FILL, ST_PEND} state_t;

    localparam int DW = 3 * SAMPLES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);
    localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(SAMPLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    fill_q, fill_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [IDX_W-1:0] out_count_q, out_count_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       last_bits_q, last_bits_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       sat_q, sat_d;

    logic          at_last;
    logic          slot_free;
    logic          ready_c;
    logic          accept;
    logic          completing;
    logic          flush_take;
    logic          pend_emit;
    logic [DW-1:0] fill_with_in;

    always_comb begin
        at_last      = (idx_q == LAST_IDX);
        slot_free    = !out_valid_q || out_ready;
        fill_with_in = fill_q;
        fill_with_in[3*int'(idx_q) +: 3] = in_bits;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (flush_take) state_d = ST_PEND;
            ST_PEND: if (slot_free)  state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    // FSM outputs; in_ready deliberately ignores in_valid and flush
    always_comb begin
        ready_c    = (state_q == ST_FILL) && !(at_last && out_valid_q && !out_ready);
        accept     = in_valid && ready_c;
        completing = accept && at_last;
        flush_take = (state_q == ST_FILL) && flush && !completing
                     && ((idx_q != '0) || accept);
        pend_emit  = (state_q == ST_PEND) && slot_free;
    end

    assign in_ready = ready_c;

    always_comb begin
        idx_d       = idx_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (completing) begin
            out_data_d  = fill_with_in;
            out_count_d = FULL_CNT;
            out_valid_d = 1'b1;
            fill_d      = '0;
            idx_d       = '0;
        end else if (accept) begin
            fill_d = fill_with_in;
            idx_d  = idx_q + 1'b1;
        end else if (pend_emit) begin
            // unused slots are already zero: fill is cleared whenever a word leaves
            out_data_d  = fill_q;
            out_count_d = idx_q;
            out_valid_d = 1'b1;
            fill_d      = '0;
            idx_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    // Toggle counters; clear beats a coinciding increment but last_bits still tracks the sample
    always_comb begin
        last_bits_d = accept ? in_bits : last_bits_q;
        sat_d       = sat_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && (in_bits[i] != last_bits_q[i])) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            if (clear_cnt) begin
                cnt_d[i] = '0;
                sat_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_bits_q <= '0;
            sat_q       <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            last_bits_q <= last_bits_d;
            sat_q       <= sat_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        toggle_cnt = '0;
        for (int i = 0; i < 3; i++) begin
            toggle_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end

    assign toggle_sat = sat_q;

endmodule

// File: tb/tb_trio_sample_packer.sv
// Bench for trio_sample_packer: directed scenarios plus a randomized run against a word/toggle model.
module tb_trio_sample_packer;

    localparam int SAMPLES = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_W2  = 2;
    localparam int IDX_W   = $clog2(SAMPLES + 1);
    localparam int DW      = 3 * SAMPLES;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [2:0]       in_bits = '0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic             clear_cnt = 1'b0;

    logic              in_ready, out_valid;
    logic [DW-1:0]     out_data;
    logic [IDX_W-1:0]  out_count;
    logic [3*CNT_W-1:0] toggle_cnt;
    logic [2:0]        toggle_sat;

    logic              in_ready2, out_valid2;
    logic [DW-1:0]     out_data2;
    logic [IDX_W-1:0]  out_count2;
    logic [3*CNT_W2-1:0] toggle_cnt2;
    logic [2:0]        toggle_sat2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trio_sample_packer #(.SAMPLES(SAMPLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .clear_cnt(clear_cnt), .toggle_cnt(toggle_cnt), .toggle_sat(toggle_sat));

    trio_sample_packer #(.SAMPLES(SAMPLES), .CNT_W(CNT_W2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready2),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_count(out_count2), .clear_cnt(clear_cnt), .toggle_cnt(toggle_cnt2), .toggle_sat(toggle_sat2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; clear_cnt = 1'b0; out_ready = 1'b0; in_bits = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic [2:0] b);
        in_valid = 1'b1;
        in_bits  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_cmp++; if (out_count !== '0) begin n_err++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
        n_cmp++; if (toggle_cnt !== '0) begin n_err++; $display("FAIL reset_toggle_cnt: got %h expected 0", toggle_cnt); end
        n_cmp++; if (toggle_sat !== 3'b000) begin n_err++; $display("FAIL reset_toggle_sat: got %b expected 000", toggle_sat); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [2:0] s [4];
        s[0] = 3'b001; s[1] = 3'b010; s[2] = 3'b100; s[3] = 3'b111;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_bits = s[k];
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready[%0d]: got %b expected 1", k, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_data !== 12'hF11) begin n_err++; $display("FAIL basic_out_data: got %h expected F11", out_data); end
        n_cmp++; if (out_count !== IDX_W'(4)) begin n_err++; $display("FAIL basic_out_count: got %0d expected 4", out_count); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_consumed: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [2:0] s [8];
        logic [DW-1:0] w1, w2;
        int n;
        logic acc;
        for (int k = 0; k < 8; k++) s[k] = 3'($urandom);
        w1 = {s[3], s[2], s[1], s[0]};
        w2 = {s[7], s[6], s[5], s[4]};
        do_reset();
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1; in_bits = s[n];
            #1;
            acc = in_ready;
            tick();
            if (acc) n++;
            if (n > 7) break;
        end
        in_bits = s[7];
        #1;
        n_cmp++; if (n != 7) begin n_err++; $display("FAIL bp_accepted: got %0d expected 7", n); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_blocked: got %b expected 0", in_ready); end
        n_cmp++; if (out_data !== w1) begin n_err++; $display("FAIL bp_word1_held: got %h expected %h", out_data, w1); end
        n_cmp++; if (out_valid !== 1'b1 || out_count !== IDX_W'(4)) begin n_err++; $display("FAIL bp_word1_valid: got v=%b c=%0d expected v=1 c=4", out_valid, out_count); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_released: got %b expected 1", in_ready); end
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_word2_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_data !== w2) begin n_err++; $display("FAIL bp_word2_data: got %h expected %h", out_data, w2); end
        n_cmp++; if (out_count !== IDX_W'(4)) begin n_err++; $display("FAIL bp_word2_count: got %0d expected 4", out_count); end
    endtask

    task automatic test_flush();
        logic [2:0] s [4];
        logic [DW-1:0] w;
        int k;
        logic acc;
        for (int i = 0; i < 4; i++) s[i] = 3'($urandom);
        w = {s[3], s[2], s[1], s[0]};
        do_reset();
        out_ready = 1'b1;
        send(3'b101);
        send(3'b011);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_pend_in_ready: got %b expected 0", in_ready); end
        for (int t = 0; t < 5 && out_valid !== 1'b1; t++) tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_timeout: got out_valid=%b expected 1", out_valid); end
        n_cmp++; if (out_data !== 12'h01D) begin n_err++; $display("FAIL flush_data: got %h expected 01D", out_data); end
        n_cmp++; if (out_count !== IDX_W'(2)) begin n_err++; $display("FAIL flush_count: got %0d expected 2", out_count); end
        k = 0;
        for (int t = 0; t < 20 && k < 4; t++) begin
            in_valid = 1'b1; in_bits = s[k];
            #1;
            acc = in_ready;
            tick();
            if (acc) k++;
        end
        in_valid = 1'b0;
        n_cmp++; if (k != 4) begin n_err++; $display("FAIL flush_refill_accepts: got %0d expected 4", k); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== w || out_count !== IDX_W'(4)) begin
            n_err++; $display("FAIL flush_next_word: got v=%b d=%h c=%0d expected v=1 d=%h c=4", out_valid, out_data, out_count, w);
        end
    endtask

    task automatic test_flush_on_last();
        do_reset();
        out_ready = 1'b1;
        send(3'b110);
        send(3'b001);
        send(3'b010);
        in_valid = 1'b1; in_bits = 3'b111; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_count !== IDX_W'(4) || out_data !== 12'hE8E) begin
            n_err++; $display("FAIL flush_last_word: got v=%b d=%h c=%0d expected v=1 d=e8e c=4", out_valid, out_data, out_count);
        end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_last_no_pend: got in_ready=%b expected 1", in_ready); end
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_last_extra_word: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_toggle();
        do_reset();
        out_ready = 1'b1;
        send(3'b000); send(3'b111); send(3'b111); send(3'b000);
        n_cmp++; if (toggle_cnt !== {8'd2, 8'd2, 8'd2}) begin n_err++; $display("FAIL tog_cnt8: got %h expected 020202", toggle_cnt); end
        n_cmp++; if (toggle_sat !== 3'b000) begin n_err++; $display("FAIL tog_sat8: got %b expected 000", toggle_sat); end
        do_reset();
        out_ready = 1'b1;
        send(3'b111); send(3'b000); send(3'b111); send(3'b000); send(3'b111);
        n_cmp++; if (toggle_cnt2 !== 6'b111111) begin n_err++; $display("FAIL tog_cnt2_sat: got %b expected 111111", toggle_cnt2); end
        n_cmp++; if (toggle_sat2 !== 3'b111) begin n_err++; $display("FAIL tog_sat2: got %b expected 111", toggle_sat2); end
        n_cmp++; if (toggle_cnt !== {8'd5, 8'd5, 8'd5} || toggle_sat !== 3'b000) begin
            n_err++; $display("FAIL tog_cnt8_five: got %h sat %b expected 050505 sat 000", toggle_cnt, toggle_sat);
        end
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        n_cmp++; if (toggle_cnt2 !== '0 || toggle_sat2 !== 3'b000) begin n_err++; $display("FAIL tog_clear: got %b sat %b expected 0 sat 000", toggle_cnt2, toggle_sat2); end
        clear_cnt = 1'b1;
        send(3'b000);
        clear_cnt = 1'b0;
        n_cmp++; if (toggle_cnt !== '0) begin n_err++; $display("FAIL tog_clear_wins: got %h expected 0", toggle_cnt); end
        send(3'b000);
        n_cmp++; if (toggle_cnt !== '0) begin n_err++; $display("FAIL tog_last_kept: got %h expected 0", toggle_cnt); end
        send(3'b001);
        n_cmp++; if (toggle_cnt !== {8'd0, 8'd0, 8'd1}) begin n_err++; $display("FAIL tog_after_clear: got %h expected 000001", toggle_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] s [4];
        logic [DW-1:0] w;
        for (int i = 0; i < 4; i++) s[i] = 3'($urandom);
        w = {s[3], s[2], s[1], s[0]};
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(3'($urandom_range(1, 7)));
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0) begin
            n_err++; $display("FAIL midrst_out: got v=%b d=%h c=%0d expected all 0", out_valid, out_data, out_count);
        end
        n_cmp++; if (toggle_cnt !== '0 || toggle_sat !== 3'b000) begin n_err++; $display("FAIL midrst_toggle: got %h sat %b expected 0", toggle_cnt, toggle_sat); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(s[i]);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== w || out_count !== IDX_W'(4)) begin
            n_err++; $display("FAIL midrst_clean_word: got v=%b d=%h c=%0d expected v=1 d=%h c=4", out_valid, out_data, out_count, w);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_data [$];
        int            exp_cnt [$];
        logic [DW-1:0] cur_word, held_data, ed, etc1;
        logic [3*CNT_W2-1:0] etc2;
        int            cur_n, ec;
        int            tc [3];
        int            tc2 [3];
        logic [2:0]    ts, ts2, last;
        logic          held, acc;
        logic [3*CNT_W-1:0] etc;
        do_reset();
        cur_word = '0; cur_n = 0; held = 1'b0; last = '0; ts = '0; ts2 = '0;
        for (int i = 0; i < 3; i++) begin tc[i] = 0; tc2[i] = 0; end
        etc1 = '0;
        for (int cyc = 0; cyc < 3040; cyc++) begin
            if (cyc < 3000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_bits   = 3'($urandom);
                flush     = ($urandom_range(0, 7) == 0);
                out_ready = ($urandom_range(0, 2) != 0);
                clear_cnt = ($urandom_range(0, 63) == 0);
            end else begin
                in_valid = 1'b0; flush = (cyc == 3000); out_ready = 1'b1; clear_cnt = 1'b0;
            end
            @(negedge clk);
            if (held) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== held_data) begin
                    n_err++; $display("FAIL rnd_hold cyc %0d: got v=%b d=%h expected v=1 d=%h", cyc, out_valid, out_data, held_data);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                if (exp_data.size() == 0) begin
                    n_err++; $display("FAIL rnd_unexpected_word cyc %0d: got d=%h c=%0d expected none", cyc, out_data, out_count);
                end else begin
                    ed = exp_data.pop_front();
                    ec = exp_cnt.pop_front();
                    if (out_data !== ed || out_count !== IDX_W'(ec)) begin
                        n_err++; $display("FAIL rnd_word cyc %0d: got d=%h c=%0d expected d=%h c=%0d", cyc, out_data, out_count, ed, ec);
                    end
                end
            end
            held = (out_valid === 1'b1) && !out_ready;
            held_data = out_data;
            acc = in_valid && (in_ready === 1'b1);
            if (clear_cnt) begin
                for (int i = 0; i < 3; i++) begin tc[i] = 0; tc2[i] = 0; end
                ts = '0; ts2 = '0;
            end else if (acc) begin
                for (int i = 0; i < 3; i++) begin
                    if (in_bits[i] != last[i]) begin
                        if (tc[i] == (1 << CNT_W) - 1) ts[i] = 1'b1; else tc[i]++;
                        if (tc2[i] == (1 << CNT_W2) - 1) ts2[i] = 1'b1; else tc2[i]++;
                    end
                end
            end
            if (acc) begin
                last = in_bits;
                cur_word = cur_word | (DW'(in_bits) << (3 * cur_n));
                cur_n++;
            end
            if (cur_n == SAMPLES) begin
                exp_data.push_back(cur_word); exp_cnt.push_back(SAMPLES);
                cur_word = '0; cur_n = 0;
            end else if (flush && cur_n > 0) begin
                exp_data.push_back(cur_word); exp_cnt.push_back(cur_n);
                cur_word = '0; cur_n = 0;
            end
            tick();
        end
        flush = 1'b0;
        n_cmp++; if (exp_data.size() != 0) begin n_err++; $display("FAIL rnd_words_missing: got %0d left expected 0", exp_data.size()); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_drain_valid: got %b expected 0", out_valid); end
        etc = '0; etc2 = '0;
        for (int i = 0; i < 3; i++) begin
            etc[CNT_W*i +: CNT_W]   = CNT_W'(tc[i]);
            etc2[CNT_W2*i +: CNT_W2] = CNT_W2'(tc2[i]);
        end
        n_cmp++; if (toggle_cnt !== etc || toggle_sat !== ts) begin
            n_err++; $display("FAIL rnd_toggle8: got %h sat %b expected %h sat %b", toggle_cnt, toggle_sat, etc, ts);
        end
        n_cmp++; if (toggle_cnt2 !== etc2 || toggle_sat2 !== ts2) begin
            n_err++; $display("FAIL rnd_toggle2: got %h sat %b expected %h sat %b", toggle_cnt2, toggle_sat2, etc2, ts2);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_flush_on_last();
        test_toggle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
